// File: rtl/score_display.sv
// Score to two-digit 7-segment display: saturating binary->BCD double-dabble, then multiplexed digit drive.
// Conversion takes 7 busy cycles with done one cycle later; strobes arriving while busy or done are dropped.
module score_display #(
  parameter int REFRESH_DIV = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] score,
  input  logic       score_valid,
  output logic       busy,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [6:0] seg,
  output logic [1:0] dig_sel
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  state_t        state, state_nxt;
  logic [14:0]   work, work_nxt, work_adj;
  logic [2:0]    iter, iter_nxt;
  logic [3:0]    tens_nxt, ones_nxt;
  logic [6:0]    score_sat;
  logic [CW-1:0] refresh_cnt;
  logic [3:0]    digit;
  logic          blank;

  assign score_sat = (score > 7'd99) ? 7'd99 : score;
  assign busy      = (state == CONVERT);
  assign done      = (state == DONE);

  // Add-3 correction on both BCD nibbles before each shift.
  always_comb begin
    work_adj = work;
    if (work[14:11] >= 4'd5) work_adj[14:11] = work[14:11] + 4'd3;
    if (work[10:7]  >= 4'd5) work_adj[10:7]  = work[10:7]  + 4'd3;
  end

  always_comb begin
    state_nxt = state;
    work_nxt  = work;
    iter_nxt  = iter;
    tens_nxt  = tens;
    ones_nxt  = ones;
    case (state)
      IDLE: begin
        if (score_valid) begin
          state_nxt = CONVERT;
          work_nxt  = {8'd0, score_sat};
          iter_nxt  = 3'd0;
        end
      end
      CONVERT: begin
        work_nxt = {work_adj[13:0], 1'b0};
        if (iter == 3'd6) begin
          // Digits load on the same edge as the final shift so they are valid alongside done.
          state_nxt = DONE;
          iter_nxt  = 3'd0;
          tens_nxt  = work_nxt[14:11];
          ones_nxt  = work_nxt[10:7];
        end else begin
          iter_nxt = iter + 3'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      work  <= '0;
      iter  <= '0;
      tens  <= '0;
      ones  <= '0;
    end else begin
      state <= state_nxt;
      work  <= work_nxt;
      iter  <= iter_nxt;
      tens  <= tens_nxt;
      ones  <= ones_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_cnt <= '0;
      dig_sel     <= 2'b01;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= '0;
      dig_sel     <= {dig_sel[0], dig_sel[1]};
    end else begin
      refresh_cnt <= refresh_cnt + CW'(1);
    end
  end

  assign digit = dig_sel[1] ? tens : ones;
  assign blank = dig_sel[1] && (tens == 4'd0);

  always_comb begin
    seg = 7'h00;
    if (!blank) begin
      case (digit)
        4'd0:    seg = 7'h3F;
        4'd1:    seg = 7'h06;
        4'd2:    seg = 7'h5B;
        4'd3:    seg = 7'h4F;
        4'd4:    seg = 7'h66;
        4'd5:    seg = 7'h6D;
        4'd6:    seg = 7'h7D;
        4'd7:    seg = 7'h07;
        4'd8:    seg = 7'h7F;
        4'd9:    seg = 7'h6F;
        default: seg = 7'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display: reset, refresh timing, conversions, dropped strobe, mid-conversion reset.
module tb_score_display;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] score;
  logic       score_valid;
  logic       busy, done;
  logic [3:0] tens, ones;
  logic [6:0] seg;
  logic [1:0] dig_sel;

  int checks = 0;
  int errors = 0;

  score_display #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .score(score), .score_valid(score_valid),
    .busy(busy), .done(done), .tens(tens), .ones(ones), .seg(seg), .dig_sel(dig_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int seg_of(input int d);
    case (d)
      0: return 'h3F; 1: return 'h06; 2: return 'h5B; 3: return 'h4F; 4: return 'h66;
      5: return 'h6D; 6: return 'h7D; 7: return 'h07; 8: return 'h7F; 9: return 'h6F;
      default: return 'h00;
    endcase
  endfunction

  task automatic wait_slot(input logic [1:0] want);
    int found = 0;
    for (int i = 0; i < 3 * DIV && found == 0; i++) begin
      @(negedge clk);
      if (dig_sel == want) found = 1;
    end
    check("slot_wait", found, 1);
  endtask

  task automatic do_conv(input int s, input int et, input int eo);
    int busy_cnt = 0;
    int done_cnt = 0;
    @(negedge clk);
    score = 7'(s); score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      @(negedge clk);
    end
    check($sformatf("busy_cycles_%0d", s), busy_cnt, 7);
    check($sformatf("early_done_%0d", s), done_cnt, 0);
    check($sformatf("done_at_8_%0d", s), int'(done), 1);
    check($sformatf("busy_in_done_%0d", s), int'(busy), 0);
    check($sformatf("tens_%0d", s), int'(tens), et);
    check($sformatf("ones_%0d", s), int'(ones), eo);
    @(negedge clk);
    check($sformatf("done_one_cycle_%0d", s), int'(done), 0);
    wait_slot(2'b10);
    check($sformatf("seg_tens_%0d", s), int'(seg), (et == 0) ? 0 : seg_of(et));
    wait_slot(2'b01);
    check($sformatf("seg_ones_%0d", s), int'(seg), seg_of(eo));
  endtask

  int vec [8][3] = '{'{42, 4, 2}, '{7, 0, 7}, '{120, 9, 9}, '{0, 0, 0},
                     '{99, 9, 9}, '{100, 9, 9}, '{59, 5, 9}, '{10, 1, 0}};

  initial begin
    int busy_cnt, done_cnt, rt, ro;
    score = '0; score_valid = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_tens", int'(tens), 0);
    check("rst_ones", int'(ones), 0);
    check("rst_dig_sel", int'(dig_sel), 1);
    check("rst_seg", int'(seg), 'h3F);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    check("rel_dig_sel", int'(dig_sel), 1);
    check("rel_seg", int'(seg), 'h3F);

    // Refresh: dig_sel flips on the 10th edge after release and every 10 edges after.
    repeat (DIV - 1) @(posedge clk);
    #1 check("refresh_hold_01", int'(dig_sel), 1);
    @(posedge clk);
    #1 check("refresh_flip_10", int'(dig_sel), 2);
    check("refresh_blank_tens", int'(seg), 0);
    repeat (DIV - 1) @(posedge clk);
    #1 check("refresh_hold_10", int'(dig_sel), 2);
    @(posedge clk);
    #1 check("refresh_flip_01", int'(dig_sel), 1);

    foreach (vec[i]) do_conv(vec[i][0], vec[i][1], vec[i][2]);

    // Strobe during CONVERT must be dropped.
    busy_cnt = 0; done_cnt = 0; rt = -1; ro = -1;
    @(negedge clk);
    score = 7'd42; score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) begin score = 7'd55; score_valid = 1'b1; end
      else score_valid = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; rt = int'(tens); ro = int'(ones); end
      @(negedge clk);
    end
    score_valid = 1'b0;
    check("drop_busy_cycles", busy_cnt, 7);
    check("drop_done_pulses", done_cnt, 1);
    check("drop_tens", rt, 4);
    check("drop_ones", ro, 2);

    // Reset in the middle of a conversion.
    @(negedge clk);
    score = 7'd99; score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", int'(busy), 1);
    reset = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_tens", int'(tens), 0);
    check("abort_ones", int'(ones), 0);
    check("abort_dig_sel", int'(dig_sel), 1);
    check("abort_seg", int'(seg), 'h3F);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
    check("post_reset_no_busy", busy_cnt, 0);
    check("post_reset_no_done", done_cnt, 0);
    check("post_reset_tens", int'(tens), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
